cgp_eval_ctrl: RTL

Evaluation sequencer for an evolved CGP LUT array on iCE40. It drives every input vector into the array's `in*` bus, waits a programmable settle time, and samples the `out*` bus. It compares each sample against a target truth table held in an external synchronous ROM and accumulates the Hamming-distance error as the candidate's fitness score. It sits between the host/evolution controller (start/done handshake) and one CGP array instance.

---
 rtl/cgp_eval_ctrl_if.sv | 29 ++
 rtl/cgp_eval_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/cgp_eval_ctrl_if.sv
// cgp_eval_ctrl_if: host handshake plus CGP-array / target-ROM bus of the
// evaluation sequencer. The slave modport is the sequencer's view; the
// master modport is the environment (host, CGP array and target ROM).
interface cgp_eval_ctrl_if #(
    parameter int N_IN    = 10,
    parameter int N_OUT   = 10,
    parameter int SCORE_W = N_IN + $clog2(N_OUT + 1)
);
    logic               start;
    logic               abort;
    logic               busy;
    logic               done;
    logic               early;
    logic [SCORE_W-1:0] score;
    logic [N_IN-1:0]    cgp_in;
    logic [N_OUT-1:0]   cgp_out;
    logic [N_IN-1:0]    exp_addr;
    logic [N_OUT-1:0]   exp_data;

    modport master (
        output start, abort, cgp_out, exp_data,
        input  busy, done, early, score, cgp_in, exp_addr
    );

    modport slave (
        input  start, abort, cgp_out, exp_data,
        output busy, done, early, score, cgp_in, exp_addr
    );
endinterface

// File: rtl/cgp_eval_ctrl.sv
// cgp_eval_ctrl: sweeps every input vector through a CGP LUT array, waits a
// settle time, samples the response and accumulates the Hamming distance to
// a target truth table read from a synchronous ROM.
// Optional feature: define CGP_EVAL_EARLY_EXIT_EN to stop the sweep as soon
// as the running score exceeds ERR_LIMIT (reported through `early`).
module cgp_eval_ctrl #(
    parameter int N_IN      = 10,
    parameter int N_OUT     = 10,
    parameter int SETTLE    = 2,
    parameter int ERR_LIMIT = 64,
    parameter int SCORE_W   = N_IN + $clog2(N_OUT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    cgp_eval_ctrl_if.slave  bus
);
    localparam int VEC_W = N_IN + 1;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [VEC_W-1:0] LAST_VEC = {1'b0, {N_IN{1'b1}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   vec_q;        // one spare bit: terminal test never wraps
    logic [CNT_W-1:0]   cnt_q;
    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W-1:0] score_next;
    logic [SCORE_W-1:0] pop;
    logic [N_OUT-1:0]   mismatch;
    logic               run;
    logic               abort_run;
    logic               early_hit;
    logic               early_flag;

    assign run       = (state_q == ST_APPLY) || (state_q == ST_SETTLE) ||
                       (state_q == ST_SAMPLE);
    assign abort_run = bus.abort && run;

    // Mismatch bit count of the current sample and the updated running score.
    always_comb begin
        mismatch = bus.cgp_out ^ bus.exp_data;
        pop      = '0;
        for (int i = 0; i < N_OUT; i++) begin
            pop = pop + SCORE_W'(mismatch[i]);
        end
        score_next = score_q + pop;
    end

`ifdef CGP_EVAL_EARLY_EXIT_EN
    localparam logic [SCORE_W-1:0] LIMIT = SCORE_W'(ERR_LIMIT);
    logic early_q;

    assign early_hit  = (score_next > LIMIT);
    assign early_flag = early_q;

    // Remember whether the sweep was cut short so `early` rides with `done`.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            early_q <= 1'b0;
        end else if (abort_run || (state_q == ST_IDLE && bus.start)) begin
            early_q <= 1'b0;
        end else if (state_q == ST_SAMPLE) begin
            early_q <= early_hit;
        end
    end
`else
    logic unused_err_limit;

    assign early_hit        = 1'b0;
    assign early_flag       = 1'b0;
    assign unused_err_limit = ^ERR_LIMIT;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; abort of a running sweep overrides every transition.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.start) state_d = ST_APPLY;
            ST_APPLY:  state_d = ST_SETTLE;
            ST_SETTLE: if (cnt_q == CNT_LAST) state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = (vec_q == LAST_VEC || early_hit) ? ST_DONE : ST_APPLY;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (abort_run) state_d = ST_IDLE;
    end

    // Vector, settle counter and score datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q   <= '0;
            cnt_q   <= '0;
            score_q <= '0;
        end else if (abort_run) begin
            score_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        vec_q   <= '0;
                        score_q <= '0;
                    end
                end
                ST_APPLY:  cnt_q <= '0;
                ST_SETTLE: cnt_q <= cnt_q + CNT_W'(1);
                ST_SAMPLE: begin
                    score_q <= score_next;
                    vec_q   <= vec_q + VEC_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; the vector bus is parked at 0 outside a run.
    always_comb begin
        bus.busy     = run;
        bus.done     = (state_q == ST_DONE);
        bus.early    = (state_q == ST_DONE) && early_flag;
        bus.score    = score_q;
        bus.cgp_in   = run ? vec_q[N_IN-1:0] : '0;
        bus.exp_addr = run ? vec_q[N_IN-1:0] : '0;
    end
endmodule
